nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that feeds the existing 4-bit ripple_carry_adder (ports A, B, Cin, Sum, Cout) one nibble per cycle.
- Carry is registered between nibbles.
- Sits directly upstream of ripple_carry_adder, instantiated internally, and presents WIDTH-bit operands/results to the datapath over valid/ready handshakes.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, number of adder passes; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands A, B, Cin are valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry into nibble 0
- out_valid  output  1  Sum/Cout are valid
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  result, registered
- Cout  output  1  carry out of the MSB nibble, registered
- busy  output  1  high in ADD or DONE

Behaviour:
- Reset (rst high at a clk edge) forces:
  - state=IDLE, Sum=0, Cout=0, out_valid=0, busy=0
  - nibble counter=0, carry register=0, operand registers=0
  - in_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture A, B into registers and Cin into the carry register; clear counter; go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, drive the adder with nibble[idx] of both operand registers and the carry register.
  - At the clk edge: Sum[4*idx+3:4*idx] <= adder Sum, carry register <= adder Cout, idx <= idx+1.
  - When idx==NIBBLES-1 at the edge: Cout <= adder Cout, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; Sum and Cout held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Timing:
  - Latency: out_valid rises NIBBLES edges after the accepting edge (4 for WIDTH=16).
  - Throughput: one operation per NIBBLES+2 cycles when out_ready is held high.
- Sum nibbles not yet written in the current operation keep their previous values. Only the final value at out_valid is architectural.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1); unsigned, no saturation.
- in_valid while busy is ignored; operands are not queued.
- out_ready while not in DONE is ignored.
- Reset mid-ADD or in DONE aborts the operation and applies the reset values above on the next edge.
- Operands are sampled only at the accepting edge. Changes to A, B, Cin afterwards have no effect.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit, registered), the signed two's-complement overflow flag.
  - Ovf = carry into the MSB nibble's top bit XOR final Cout. Compute it as A[W-1]^B[W-1]^Sum[W-1], XORed with Cout.
  - Ovf is updated together with Cout on the last ADD edge, held in DONE, and reset to 0.
- Not defined: no Ovf port; behaviour otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1, A=0xFFFF -> Sum=0x0000, Cout=0, out_valid=0, busy=0; in_ready=1 the cycle after rst drops.
- Basic add: A=0x0001, B=0x0001, Cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept, Sum=0x0002, Cout=0; in_ready back to 1 two cycles later.
- Carry chaining:
  - A=0x000F, B=0x0001, Cin=0 -> Sum=0x0010.
  - A=0x0FFF, B=0x0000, Cin=1 -> Sum=0x1000, Cout=0.
- Wrap-around:
  - A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1.
  - A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1.
- Backpressure: A=0x1234, B=0x4321, out_ready=0 for 6 cycles, with new in_valid pulsed during the stall -> Sum=0x5555 held, in_ready=0 throughout, new operands dropped; result consumed on the first out_ready=1 cycle.
- Reset mid-operation and overflow:
  - Assert rst on the 2nd ADD cycle of A=0xAAAA, B=0x5555 -> next cycle IDLE, out_valid=0, Sum=0.
  - With NIBBLE_SERIAL_ADDER_OVF_EN: A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add built from NIBBLES passes through a 4-bit ripple adder, with the carry registered between passes; result is valid NIBBLES cycles after accept.
// One operation in flight; the result is held until out_ready. Optional Ovf port under NIBBLE_SERIAL_ADDER_OVF_EN.

module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic c;

  always_comb begin
    Sum = '0;
    c   = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               accept;
  logic [3:0]         nib_a, nib_b, add_sum;
  logic               add_cout;

  assign nib_a = a_q[{idx, 2'b00} +: 4];
  assign nib_b = b_q[{idx, 2'b00} +: 4];
  assign last  = (idx == IDX_W'(NIBBLES - 1));

  ripple_carry_adder u_rca (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        carry_q <= Cin;
        idx     <= '0;
      end
      if (state == ADD) begin
        Sum[{idx, 2'b00} +: 4] <= add_sum;
        carry_q                <= add_cout;
        idx                    <= idx + 1'b1;
        if (last) begin
          Cout      <= add_cout;
          out_valid <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          // Carry into the top bit recovered from the operand and sum bits.
          Ovf       <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_sum[3] ^ add_cout;
`endif
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, corner sequences, and random ops against an arithmetic model.
module tb_nibble_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .Ovf       (ovf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint s, lim;
    s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    lim = longint'(1) << (W - 1);
    return (s >= lim) || (s < -lim);
  endfunction

  // One full operation: accept, latency, result, optional stall with ignored in_valid, consume.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf, input int stall);
    int lat;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, N);
    if (!out_valid) begin
      rst = 1'b1; step(); rst = 1'b0;
      return;
    end
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, eovf);
`endif
    check({tag, "_in_ready_done"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i == 1);
      a = ~xa; b = ~xb;
      step();
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_sum"}, sum, esum);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check({tag, "_consumed"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  vec_t tbl[7];
  logic [W:0] r;

  initial begin
    tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0);

    // Backpressure: stalled result must hold and the pulsed operands must be dropped.
    run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_dropped_valid", out_valid, 0);
      check("bp_dropped_busy", busy, 0);
    end

    // Reset on the second ADD cycle aborts the operation.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    run_op("after_rst", tbl[1].a, tbl[1].b, tbl[1].cin, tbl[1].sum, tbl[1].cout, tbl[1].ovf, 0);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] xa, xb;
      logic         xc;
      xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
      r  = model_add(xa, xb, xc);
      run_op($sformatf("rand%0d", i), xa, xb, xc, r[W-1:0], r[W], model_ovf(xa, xb, xc),
             int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
